// File: rtl/mem_port_pkg.sv
// ============================================================================
//  Module   : mem_port_pkg
//  Brief    : Shared types and default widths for the memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_pkg;

    localparam int c_default_addr_w = 12;
    localparam int c_default_data_w = 32;

    typedef enum logic {
        CH_IF = 1'b0,
        CH_D  = 1'b1
    } channel_e;

    typedef struct packed {
        logic     valid;
        channel_e ch;
        logic     err;
    } rsp_tag_t;

endpackage

`default_nettype wire

// File: rtl/sram_be.sv
// ============================================================================
//  Module   : sram_be
//  Brief    : Single-port synchronous SRAM, byte-lane write, registered
//             read-first output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_be
    import mem_port_pkg::*;
#(
    parameter int ADDR_W = c_default_addr_w,
    parameter int DATA_W = c_default_data_w
) (
    input  logic                clk,
    input  logic                i_en,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_be,
    output logic [DATA_W-1:0]   o_q
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Read samples the old word, so a same-cycle write is seen one access later.
    always_ff @(posedge clk) begin
        if (i_en) begin
            o_q <= r_mem[i_addr];
            for (int i = 0; i < DATA_W/8; i++) begin
                if (i_we && i_be[i]) begin
                    r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Fetch/data arbiter in front of a shared single-port SRAM with a
//             bounded-wait fetch guarantee. Byte-masked writes are enabled by
//             defining MEM_PORT_BYTE_WRITE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int ADDR_W     = c_default_addr_w,
    parameter int DATA_W     = c_default_data_w,
    parameter int STARVE_MAX = 3
) (
    input  logic                mem_clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [29:0]         if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [29:0]         d_addr,
    input  logic                d_wren,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                addr_err
);

    localparam int                 c_cnt_w      = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

    logic [c_cnt_w-1:0]  r_starve_cnt;
    rsp_tag_t            r_tag;
    logic                r_rsp_wr;
    logic                w_force_if;
    logic                w_grant_if;
    logic                w_grant_d;
    logic [29:0]         w_addr;
    logic                w_err;
    logic                w_we;
    logic [DATA_W/8-1:0] w_be;
    logic [DATA_W-1:0]   w_q;

    assign w_force_if = (r_starve_cnt == c_starve_max);

    always_comb begin
        w_grant_if = 1'b0;
        w_grant_d  = 1'b0;
        if (!stall && !reset) begin
            if (w_force_if && if_req_valid) begin
                w_grant_if = 1'b1;
            end else if (d_req_valid) begin
                w_grant_d = 1'b1;
            end else if (if_req_valid) begin
                w_grant_if = 1'b1;
            end
        end
    end

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;

    assign w_addr = w_grant_if ? if_addr : d_addr;
    assign w_err  = |w_addr[29:ADDR_W];
    assign w_we   = w_grant_d && d_wren && !w_err;

`ifdef MEM_PORT_BYTE_WRITE_EN
    assign w_be = d_be;
`else
    logic w_unused_be;
    assign w_unused_be = ^d_be;
    assign w_be        = '1;
`endif

    // Stall-blocked cycles count too, so a saturated counter survives a stall.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!if_req_valid || w_grant_if) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            r_tag    <= '{valid: 1'b0, ch: CH_IF, err: 1'b0};
            r_rsp_wr <= 1'b0;
        end else begin
            r_tag.valid <= w_grant_if || w_grant_d;
            r_tag.ch    <= w_grant_d ? CH_D : CH_IF;
            r_tag.err   <= w_err;
            r_rsp_wr    <= w_grant_d && d_wren;
        end
    end

    sram_be #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk     (mem_clk),
        .i_en    (w_grant_if || w_grant_d),
        .i_we    (w_we),
        .i_addr  (w_addr[ADDR_W-1:0]),
        .i_wdata (d_wdata),
        .i_be    (w_be),
        .o_q     (w_q)
    );

    // Reset gates the in-flight response so it never reaches a consumer.
    assign if_rsp_valid = r_tag.valid && (r_tag.ch == CH_IF) && !reset;
    assign d_rsp_valid  = r_tag.valid && (r_tag.ch == CH_D)  && !reset;
    assign addr_err     = r_tag.valid && r_tag.err && !reset;
    assign if_rsp_data  = (if_rsp_valid && !r_tag.err) ? w_q : '0;
    assign d_rsp_data   = (d_rsp_valid && !r_tag.err && !r_rsp_wr) ? w_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Scoreboard bench for mem_port_arbiter with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

`ifdef MEM_PORT_BYTE_WRITE_EN
    localparam logic [31:0] c_exp_merge = 32'h11BB33DD;
`else
    localparam logic [31:0] c_exp_merge = 32'hAABBCCDD;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        mem_clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [29:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [29:0] d_addr;
    logic        d_wren;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        addr_err;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t q_if[$];
    exp_t q_d[$];

    mem_port_arbiter dut (
        .mem_clk      (mem_clk),
        .reset        (reset),
        .stall        (stall),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_addr       (d_addr),
        .d_wren       (d_wren),
        .d_wdata      (d_wdata),
        .d_be         (d_be),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .addr_err     (addr_err)
    );

    always #5 mem_clk = ~mem_clk;
    always @(posedge mem_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_exp(input logic ch_d, input logic [31:0] data, input logic err);
        exp_t e;
        e.data = data;
        e.err  = err;
        e.cyc  = cyc + 1;
        if (ch_d) q_d.push_back(e);
        else      q_if.push_back(e);
    endtask

    task automatic do_d(input logic [29:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_data, input logic exp_err);
        int waited = 0;
        d_req_valid = 1'b1;
        d_addr = addr; d_wren = wr; d_wdata = wdata; d_be = be;
        @(negedge mem_clk);
        while (!d_req_ready && waited < 20) begin
            @(negedge mem_clk);
            waited++;
        end
        if (!d_req_ready) check("d_grant_timeout", 32'd0, 32'd1);
        else push_exp(1'b1, exp_data, exp_err);
        @(posedge mem_clk); #1;
        d_req_valid = 1'b0;
    endtask

    task automatic do_if(input logic [29:0] addr, input logic [31:0] exp_data, input logic exp_err);
        int waited = 0;
        if_req_valid = 1'b1;
        if_addr = addr;
        @(negedge mem_clk);
        while (!if_req_ready && waited < 20) begin
            @(negedge mem_clk);
            waited++;
        end
        if (!if_req_ready) check("if_grant_timeout", 32'd0, 32'd1);
        else push_exp(1'b0, exp_data, exp_err);
        @(posedge mem_clk); #1;
        if_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge mem_clk);
        #1;
    endtask

    // Monitor: pops one expectation per presented response.
    initial begin
        exp_t e;
        forever begin
            @(negedge mem_clk);
            if (d_rsp_valid) begin
                if (q_d.size() == 0) check("d_rsp_unexpected", 32'd1, 32'd0);
                else begin
                    e = q_d.pop_front();
                    check("d_rsp_data", d_rsp_data, e.data);
                    check("d_rsp_err", {31'd0, addr_err}, {31'd0, e.err});
                    check("d_rsp_latency", cyc, e.cyc);
                end
            end
            if (if_rsp_valid) begin
                if (q_if.size() == 0) check("if_rsp_unexpected", 32'd1, 32'd0);
                else begin
                    e = q_if.pop_front();
                    check("if_rsp_data", if_rsp_data, e.data);
                    check("if_rsp_err", {31'd0, addr_err}, {31'd0, e.err});
                    check("if_rsp_latency", cyc, e.cyc);
                end
            end
            if (addr_err && !d_rsp_valid && !if_rsp_valid) check("addr_err_stray", 32'd1, 32'd0);
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0;
        if_req_valid = 1'b1; if_addr = '0;
        d_req_valid = 1'b1; d_addr = '0; d_wren = 1'b0; d_wdata = '0; d_be = '0;
        repeat (3) @(posedge mem_clk);
        @(negedge mem_clk);
        check("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
        check("rst_d_ready", {31'd0, d_req_ready}, 32'd0);
        check("rst_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
        check("rst_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_d_rsp_data", d_rsp_data, 32'd0);
        check("rst_if_rsp_data", if_rsp_data, 32'd0);
        check("rst_starve_cnt", 32'(dut.r_starve_cnt), 32'd0);
        @(posedge mem_clk); #1;
        reset = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0;
        idle(1);

        // Basic write then read, back-to-back grants.
        do_d(30'h010, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        do_d(30'h010, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        idle(2);

        // Byte-lane merge.
        do_d(30'h020, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0);
        do_d(30'h020, 1'b1, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        do_d(30'h020, 1'b0, 32'h0, 4'h0, c_exp_merge, 1'b0);
        idle(2);

        // Out-of-range aliasing onto 0x000 must not corrupt it.
        do_d(30'h000, 1'b1, 32'h55667788, 4'hF, 32'h0, 1'b0);
        do_d(30'h1000, 1'b1, 32'h99999999, 4'hF, 32'h0, 1'b1);
        do_d(30'h1000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        do_d(30'h000, 1'b0, 32'h0, 4'h0, 32'h55667788, 1'b0);
        do_if(30'h2000_0010, 32'h0, 1'b1);
        do_if(30'h010, 32'hDEADBEEF, 1'b0);
        idle(2);

        // Starvation bound: fetch every fourth cycle.
        if_req_valid = 1'b1; if_addr = 30'h010;
        d_req_valid = 1'b1; d_addr = 30'h020; d_wren = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge mem_clk);
            check("starve_cnt", 32'(dut.r_starve_cnt), k % 4);
            check("starve_if_ready", {31'd0, if_req_ready}, (k % 4 == 3) ? 32'd1 : 32'd0);
            if (if_req_ready) push_exp(1'b0, 32'hDEADBEEF, 1'b0);
            if (d_req_ready)  push_exp(1'b1, c_exp_merge, 1'b0);
        end
        @(posedge mem_clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        idle(2);

        // Stall with both pending: nothing granted, then fetch first.
        stall = 1'b1;
        if_req_valid = 1'b1; if_addr = 30'h010;
        d_req_valid = 1'b1; d_addr = 30'h000; d_wren = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge mem_clk);
            check("stall_if_ready", {31'd0, if_req_ready}, 32'd0);
            check("stall_d_ready", {31'd0, d_req_ready}, 32'd0);
        end
        @(posedge mem_clk); #1;
        stall = 1'b0;
        @(negedge mem_clk);
        check("stall_force_held", 32'(dut.r_starve_cnt), 32'd3);
        check("unstall_if_first", {31'd0, if_req_ready}, 32'd1);
        check("unstall_d_wait", {31'd0, d_req_ready}, 32'd0);
        if (if_req_ready) push_exp(1'b0, 32'hDEADBEEF, 1'b0);
        @(posedge mem_clk); #1;
        if_req_valid = 1'b0;
        @(negedge mem_clk);
        check("unstall_d_next", {31'd0, d_req_ready}, 32'd1);
        if (d_req_ready) push_exp(1'b1, 32'h55667788, 1'b0);
        @(posedge mem_clk); #1;
        d_req_valid = 1'b0;
        idle(2);

        // Reset while a fetch response is in flight: dropped.
        if_req_valid = 1'b1; if_addr = 30'h010;
        @(negedge mem_clk);
        check("rstflight_grant", {31'd0, if_req_ready}, 32'd1);
        @(posedge mem_clk); #1;
        if_req_valid = 1'b0; reset = 1'b1;
        @(negedge mem_clk);
        check("rstflight_if_valid", {31'd0, if_rsp_valid}, 32'd0);
        @(posedge mem_clk); #1;
        reset = 1'b0;
        @(negedge mem_clk);
        check("rstflight_after", {31'd0, if_rsp_valid}, 32'd0);
        @(posedge mem_clk); #1;
        do_if(30'h010, 32'hDEADBEEF, 1'b0);
        idle(3);

        check("if_queue_drained", q_if.size(), 32'd0);
        check("d_queue_drained", q_d.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
